// File: rtl/hamming_encoder.sv
// Streaming Hamming(7,4) encoder.
// Accepts DATA_W-bit words on a valid/ready input. Each word is split into
// 4-bit nibbles, least significant nibble first. Each nibble leaves as a
// registered 7-bit codeword on a valid/ready output.
// A one-shot error injector can flip a single codeword bit. Downstream
// correctors can be exercised with it.
// Codeword bit i carries Hamming position i+1:
//   {d3, d2, d1, p4, d0, p2, p1}
// DATA_W must be a multiple of 4 and at least 4.
module hamming_encoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        out_code,
    output logic              out_last,
    output logic              out_injected,
    input  logic              inj_req,
    input  logic [2:0]        inj_pos,
    output logic [CNT_W-1:0]  cw_count
);

    localparam int NUM_NIB = DATA_W / 4;
    localparam int NIB_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [NIB_W-1:0] LAST_IDX = NIB_W'(NUM_NIB - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Even-parity Hamming(7,4) encoding of one nibble.
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // One-hot flip mask for a Hamming position (1..7).
    // Position 0 or a disarmed injector yields no flip.
    function automatic logic [6:0] inject_mask(input logic armed, input logic [2:0] pos);
        logic [6:0] mask;
        mask = 7'b000_0000;
        if (armed && (pos != 3'd0)) begin
            mask = 7'b000_0001 << (pos - 3'd1);
        end else begin
            mask = 7'b000_0000;
        end
        return mask;
    endfunction

    // Architectural state.
    state_t             r_state;
    logic [DATA_W-1:0]  r_word;         // nibbles still to be sent, next one in [3:0]
    logic [NIB_W-1:0]   r_nib_idx;      // index of the nibble currently presented
    logic               r_inj_armed;
    logic [2:0]         r_inj_pos;
    logic [6:0]         r_out_code;
    logic               r_out_last;
    logic               r_out_injected;
    logic [CNT_W-1:0]   r_cw_count;

    // Next-cycle decisions.
    logic               w_accept;
    logic               w_out_hs;
    logic               w_advance;
    logic               w_finish;
    logic               w_load;
    logic [3:0]         w_load_nib;
    logic [NIB_W-1:0]   w_load_idx;
    logic [6:0]         w_load_code;
    logic               w_inj_arm_req;
    logic [DATA_W-1:0]  w_word_next;

    // Ready/valid are decoded from the state register only.
    // This keeps out_ready off any combinational path to in_ready.
    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_SEND);
    assign out_code     = r_out_code;
    assign out_last     = r_out_last;
    assign out_injected = r_out_injected;
    assign cw_count     = r_cw_count;

    // Handshake decode and selection of the next codeword to load.
    always_comb begin
        w_accept      = in_valid && in_ready;
        w_out_hs      = out_valid && out_ready;
        w_advance     = w_out_hs && (r_nib_idx != LAST_IDX);
        w_finish      = w_out_hs && (r_nib_idx == LAST_IDX);
        w_load        = w_accept || w_advance;
        w_inj_arm_req = inj_req && (inj_pos != 3'd0);
        if (w_accept) begin
            w_load_nib  = in_data[3:0];
            w_load_idx  = {NIB_W{1'b0}};
            w_word_next = in_data >> 4;
        end else begin
            w_load_nib  = r_word[3:0];
            w_load_idx  = r_nib_idx + NIB_W'(1);
            w_word_next = r_word >> 4;
        end
        // The arm seen here is the one registered before this cycle.
        // A request arriving alongside a load therefore applies to the next load.
        w_load_code = hamming_encode(w_load_nib) ^ inject_mask(r_inj_armed, r_inj_pos);
    end

    // FSM, output registers, injector arm and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_word         <= {DATA_W{1'b0}};
            r_nib_idx      <= {NIB_W{1'b0}};
            r_inj_armed    <= 1'b0;
            r_inj_pos      <= 3'd0;
            r_out_code     <= 7'd0;
            r_out_last     <= 1'b0;
            r_out_injected <= 1'b0;
            r_cw_count     <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_finish) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A codeword is only replaced on accept or on a non-final handshake.
            // This keeps it stable under backpressure.
            if (w_load) begin
                r_word         <= w_word_next;
                r_nib_idx      <= w_load_idx;
                r_out_code     <= w_load_code;
                r_out_last     <= (w_load_idx == LAST_IDX);
                r_out_injected <= r_inj_armed;
            end

            if (w_out_hs) begin
                r_cw_count <= r_cw_count + CNT_W'(1);
            end

            // A new request wins over the clear from a simultaneous load.
            if (w_inj_arm_req) begin
                r_inj_armed <= 1'b1;
                r_inj_pos   <= inj_pos;
            end else if (w_load) begin
                r_inj_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed self-checking bench for hamming_encoder.
// The main instance uses DATA_W=8 and CNT_W=16.
// A second instance (DATA_W=4, CNT_W=4) covers single-nibble words and counter wrap.
module tb_hamming_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_code;
    logic        out_last;
    logic        out_injected;
    logic        inj_req;
    logic [2:0]  inj_pos;
    logic [15:0] cw_count;

    logic        in_valid2;
    logic        in_ready2;
    logic [3:0]  in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [6:0]  out_code2;
    logic        out_last2;
    logic        out_injected2;
    logic        inj_req2;
    logic [2:0]  inj_pos2;
    logic [3:0]  cw_count2;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cw = 16'd0;

    hamming_encoder #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_last(out_last), .out_injected(out_injected),
        .inj_req(inj_req), .inj_pos(inj_pos), .cw_count(cw_count)
    );

    hamming_encoder #(.DATA_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_code(out_code2),
        .out_last(out_last2), .out_injected(out_injected2),
        .inj_req(inj_req2), .inj_pos(inj_pos2), .cw_count(cw_count2)
    );

    // Corrector-side syndrome, written from the parity-check equations.
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_cw = 16'd0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_code !== 7'h00) begin bad++; $display("FAIL reset_out_code: got %h expected 00", out_code); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        total++; if (out_injected !== 1'b0) begin bad++; $display("FAIL reset_out_injected: got %b expected 0", out_injected); end
        total++; if (cw_count !== 16'd0) begin bad++; $display("FAIL reset_cw_count: got %0d expected 0", cw_count); end
        total++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || cw_count2 !== 4'd0) begin bad++; $display("FAIL reset_dut4: got rdy=%b vld=%b cnt=%0d expected 1 0 0", in_ready2, out_valid2, cw_count2); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        step();
        in_valid  = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid0: got %b expected 1", out_valid); end
        total++; if (out_code !== 7'h07) begin bad++; $display("FAIL basic_code0: got %h expected 07", out_code); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL basic_last0: got %b expected 0", out_last); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_busy: got %b expected 0", in_ready); end
        step();
        total++; if (out_code !== 7'h55) begin bad++; $display("FAIL basic_code1: got %h expected 55", out_code); end
        total++; if (out_last !== 1'b1) begin bad++; $display("FAIL basic_last1: got %b expected 1", out_last); end
        total++; if (cw_count !== exp_cw + 16'd1) begin bad++; $display("FAIL basic_cnt1: got %0d expected %0d", cw_count, exp_cw + 16'd1); end
        step();
        exp_cw = exp_cw + 16'd2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_end: got %b expected 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_end: got %b expected 1", in_ready); end
        total++; if (cw_count !== exp_cw) begin bad++; $display("FAIL basic_cnt2: got %0d expected %0d", cw_count, exp_cw); end
    endtask

    task automatic test_nibbles();
        logic [7:0] words [2];
        logic [6:0] codes [4];
        logic [3:0] nibs  [3];
        logic [6:0] ncode [3];
        words[0] = 8'hF0; words[1] = 8'h55;
        codes[0] = 7'h00; codes[1] = 7'h7F; codes[2] = 7'h2D; codes[3] = 7'h2D;
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1;
            in_data  = words[w];
            step();
            in_valid = 1'b0;
            for (int n = 0; n < 2; n++) begin
                total++; if (out_code !== codes[2*w+n]) begin bad++; $display("FAIL nib_code w%0d n%0d: got %h expected %h", w, n, out_code, codes[2*w+n]); end
                total++; if (syndrome(out_code) !== 3'b000) begin bad++; $display("FAIL nib_syndrome w%0d n%0d: got %b expected 000", w, n, syndrome(out_code)); end
                total++; if (out_last !== (n == 1)) begin bad++; $display("FAIL nib_last w%0d n%0d: got %b expected %b", w, n, out_last, (n == 1)); end
                step();
            end
            exp_cw = exp_cw + 16'd2;
        end
        // Single-nibble words on the 4-bit instance.
        nibs[0] = 4'h0; nibs[1] = 4'hF; nibs[2] = 4'h5;
        ncode[0] = 7'h00; ncode[1] = 7'h7F; ncode[2] = 7'h2D;
        out_ready2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid2 = 1'b1;
            in_data2  = nibs[k];
            step();
            in_valid2 = 1'b0;
            total++; if (out_code2 !== ncode[k]) begin bad++; $display("FAIL nib4_code %0d: got %h expected %h", k, out_code2, ncode[k]); end
            total++; if (out_last2 !== 1'b1) begin bad++; $display("FAIL nib4_last %0d: got %b expected 1", k, out_last2); end
            total++; if (syndrome(out_code2) !== 3'b000) begin bad++; $display("FAIL nib4_syndrome %0d: got %b expected 000", k, syndrome(out_code2)); end
            step();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        step();
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_code !== 7'h07 || out_last !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold %0d: got code=%h last=%b vld=%b rdy=%b expected 07 0 1 0", i, out_code, out_last, out_valid, in_ready); end
            step();
        end
        total++; if (cw_count !== exp_cw) begin bad++; $display("FAIL bp_cnt_hold: got %0d expected %0d", cw_count, exp_cw); end
        out_ready = 1'b1;
        total++; if (out_code !== 7'h07) begin bad++; $display("FAIL bp_release0: got %h expected 07", out_code); end
        step();
        total++; if (out_code !== 7'h55 || out_last !== 1'b1) begin bad++; $display("FAIL bp_release1: got code=%h last=%b expected 55 1", out_code, out_last); end
        step();
        exp_cw = exp_cw + 16'd2;
        total++; if (in_ready !== 1'b1 || cw_count !== exp_cw) begin bad++; $display("FAIL bp_end: got rdy=%b cnt=%0d expected 1 %0d", in_ready, cw_count, exp_cw); end
    endtask

    task automatic test_inject();
        out_ready = 1'b1;
        // Arm position 3 while idle, then issue a request with position 0.
        // The position-0 request must leave the arm as it is.
        inj_req = 1'b1; inj_pos = 3'd3;
        step();
        inj_pos = 3'd0;
        step();
        inj_req = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1;
        step();
        in_valid = 1'b0;
        total++; if (out_code !== 7'h03 || out_injected !== 1'b1) begin bad++; $display("FAIL inj_first: got code=%h inj=%b expected 03 1", out_code, out_injected); end
        total++; if (syndrome(out_code) !== 3'd3) begin bad++; $display("FAIL inj_syndrome: got %0d expected 3", syndrome(out_code)); end
        step();
        total++; if (out_code !== 7'h55 || out_injected !== 1'b0) begin bad++; $display("FAIL inj_second: got code=%h inj=%b expected 55 0", out_code, out_injected); end
        step();
        // A position-0 request while disarmed must not arm the injector.
        inj_req = 1'b1; inj_pos = 3'd0;
        step();
        inj_req = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1;
        step();
        in_valid = 1'b0;
        total++; if (out_code !== 7'h07 || out_injected !== 1'b0) begin bad++; $display("FAIL inj_noop: got code=%h inj=%b expected 07 0", out_code, out_injected); end
        step();
        step();
        // A request coinciding with a load applies to the following codeword.
        inj_req = 1'b1; inj_pos = 3'd7;
        in_valid = 1'b1; in_data = 8'hB1;
        step();
        inj_req = 1'b0; in_valid = 1'b0;
        total++; if (out_code !== 7'h07 || out_injected !== 1'b0) begin bad++; $display("FAIL inj_same_cycle0: got code=%h inj=%b expected 07 0", out_code, out_injected); end
        step();
        total++; if (out_code !== 7'h15 || out_injected !== 1'b1 || out_last !== 1'b1) begin bad++; $display("FAIL inj_same_cycle1: got code=%h inj=%b last=%b expected 15 1 1", out_code, out_injected, out_last); end
        step();
        exp_cw = exp_cw + 16'd6;
        total++; if (cw_count !== exp_cw) begin bad++; $display("FAIL inj_cnt: got %0d expected %0d", cw_count, exp_cw); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        step();
        // The word is already latched. New in_data must not leak into the second nibble.
        in_data   = 8'h0F;
        total++; if (out_code !== 7'h07) begin bad++; $display("FAIL b2b_w0n0: got %h expected 07", out_code); end
        step();
        total++; if (out_code !== 7'h55 || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_w0n1: got code=%h rdy=%b expected 55 0", out_code, in_ready); end
        step();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: got rdy=%b vld=%b expected 1 0", in_ready, out_valid); end
        step();
        in_valid = 1'b0;
        total++; if (out_code !== 7'h7F || out_last !== 1'b0) begin bad++; $display("FAIL b2b_w1n0: got code=%h last=%b expected 7f 0", out_code, out_last); end
        step();
        total++; if (out_code !== 7'h00 || out_last !== 1'b1) begin bad++; $display("FAIL b2b_w1n1: got code=%h last=%b expected 00 1", out_code, out_last); end
        step();
        exp_cw = exp_cw + 16'd4;
        total++; if (cw_count !== exp_cw) begin bad++; $display("FAIL b2b_cnt: got %0d expected %0d", cw_count, exp_cw); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        step();
        in_valid  = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cw = 16'd0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_state: got vld=%b rdy=%b expected 0 1", out_valid, in_ready); end
        total++; if (cw_count !== 16'd0) begin bad++; $display("FAIL rmid_cnt: got %0d expected 0", cw_count); end
        in_valid = 1'b1;
        in_data  = 8'h50;
        step();
        in_valid = 1'b0;
        total++; if (out_code !== 7'h00 || out_last !== 1'b0 || out_injected !== 1'b0) begin bad++; $display("FAIL rmid_n0: got code=%h last=%b inj=%b expected 00 0 0", out_code, out_last, out_injected); end
        step();
        total++; if (out_code !== 7'h2D || out_last !== 1'b1) begin bad++; $display("FAIL rmid_n1: got code=%h last=%b expected 2d 1", out_code, out_last); end
        step();
        total++; if (cw_count !== 16'd2) begin bad++; $display("FAIL rmid_cnt2: got %0d expected 2", cw_count); end
    endtask

    task automatic test_wrap();
        logic [3:0] e;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        in_data2   = 4'h5;
        for (int k = 1; k <= 16; k++) begin
            step();
            total++; if (out_valid2 !== 1'b1 || out_code2 !== 7'h2D) begin bad++; $display("FAIL wrap_code %0d: got vld=%b code=%h expected 1 2d", k, out_valid2, out_code2); end
            step();
            e = 4'(k);
            total++; if (cw_count2 !== e) begin bad++; $display("FAIL wrap_cnt %0d: got %0d expected %0d", k, cw_count2, e); end
        end
        in_valid2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        inj_req = 1'b0; inj_pos = 3'd0;
        in_valid2 = 1'b0; in_data2 = 4'h0; out_ready2 = 1'b0;
        inj_req2 = 1'b0; inj_pos2 = 3'd0;
        test_reset();
        test_basic();
        test_nibbles();
        test_backpressure();
        test_inject();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
